// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the neural-network op-code controller and its
// program sequencer: opcode values, instruction width and sequencer states.
package nn_ctrl_pkg;

  localparam int OP_W    = 4;
  localparam int PA_W    = 4;
  localparam int PB_W    = 4;
  localparam int INSTR_W = OP_W + PA_W + PB_W;

  localparam logic [3:0] OP_HALT              = 4'd0;
  localparam logic [3:0] OP_SET_ACT_DENSE     = 4'd1;
  localparam logic [3:0] OP_SET_COST          = 4'd2;
  localparam logic [3:0] OP_LOAD_WEIGHT       = 4'd3;
  localparam logic [3:0] OP_LOAD_INPUT_LABEL  = 4'd4;
  localparam logic [3:0] OP_SET_LEARNING_RATE = 4'd5;
  localparam logic [3:0] OP_UPDATE_WEIGHT     = 4'd6;
  localparam logic [3:0] OP_STALL             = 4'd7;
  localparam logic [3:0] OP_LOAD_Z            = 4'd8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    EXEC  = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  // Saturating 32-bit increment used for the per-instruction cycle counter.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/code_sequencer.sv
// Program sequencer in front of the combinational op-code controller.
// Fetches {op,param_a,param_b} words from a synchronous instruction memory,
// presents them to the controller during EXEC and advances the program
// counter from the controller's code_active / code_reset / reset outputs.
// Optional feature: define SEQ_EPOCH_LOOP_EN to repeat the whole program
// epoch_count times before the single done pulse.
module code_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int OP_SIZE      = 4,
  parameter int PARAM_A_SIZE = 4,
  parameter int PARAM_B_SIZE = 4,
  parameter int ADDR_W       = 8
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  input  logic [ADDR_W-1:0]                            prog_len,
`ifdef SEQ_EPOCH_LOOP_EN
  input  logic [15:0]                                  epoch_count,
  output logic [15:0]                                  epoch_idx,
`endif
  output logic                                         busy,
  output logic                                         done,
  output logic                                         err,
  output logic                                         imem_rd,
  output logic [ADDR_W-1:0]                            imem_addr,
  input  logic [OP_SIZE+PARAM_A_SIZE+PARAM_B_SIZE-1:0] imem_data,
  output logic [OP_SIZE-1:0]                           op,
  output logic [PARAM_A_SIZE-1:0]                      param_a,
  output logic [PARAM_B_SIZE-1:0]                      param_b,
  output logic [PARAM_A_SIZE+PARAM_B_SIZE-1:0]         param_c,
  output logic [31:0]                                  code_count,
  output logic                                         enable,
  output logic [ADDR_W-1:0]                            pc,
  input  logic                                         ctl_reset,
  input  logic                                         ctl_code_reset,
  input  logic                                         ctl_code_active
);

  localparam int IW  = OP_SIZE + PARAM_A_SIZE + PARAM_B_SIZE;
  localparam int PCW = PARAM_A_SIZE + PARAM_B_SIZE;

  seq_state_t        r_state;
  seq_state_t        w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] r_prog_len;
  logic [ADDR_W-1:0] w_prog_len_nxt;
  logic [IW-1:0]     r_instr;
  logic [IW-1:0]     w_instr_nxt;
  logic [31:0]       r_code_count;
  logic [31:0]       w_code_count_nxt;
  logic              r_err;
  logic              w_err_nxt;
  logic              r_zero_done;
  logic              w_zero_done_nxt;
  logic [OP_SIZE-1:0] w_op;
  logic              w_is_halt;
  logic              w_is_illegal;
  logic              w_finish;
  logic              w_restart;
  logic              w_loop_taken;
  logic              w_busy;
  logic              w_done;
  logic              w_imem_rd;
  logic              w_enable;

`ifdef SEQ_EPOCH_LOOP_EN
  logic [15:0] r_epoch_cnt;
  logic [15:0] w_epoch_cnt_nxt;
  logic [15:0] r_epoch_idx;
  logic [15:0] w_epoch_idx_nxt;

  // Another pass is due while the next epoch index is still below the count.
  assign w_restart = (({1'b0, r_epoch_idx} + 17'd1) < {1'b0, r_epoch_cnt});
  assign epoch_idx = r_epoch_idx;
`else
  assign w_restart = 1'b0;
`endif

  assign w_op         = r_instr[IW-1 -: OP_SIZE];
  assign w_is_halt    = (w_op == OP_SIZE'(OP_HALT));
  assign w_is_illegal = (w_op > OP_SIZE'(OP_LOAD_Z));
  assign w_pc_inc     = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_pc         <= {ADDR_W{1'b0}};
      r_prog_len   <= {ADDR_W{1'b0}};
      r_instr      <= {IW{1'b0}};
      r_code_count <= 32'd0;
      r_err        <= 1'b0;
      r_zero_done  <= 1'b0;
`ifdef SEQ_EPOCH_LOOP_EN
      r_epoch_cnt  <= 16'd1;
      r_epoch_idx  <= 16'd0;
`endif
    end else begin
      r_state      <= w_next_state;
      r_pc         <= w_pc_nxt;
      r_prog_len   <= w_prog_len_nxt;
      r_instr      <= w_instr_nxt;
      r_code_count <= w_code_count_nxt;
      r_err        <= w_err_nxt;
      r_zero_done  <= w_zero_done_nxt;
`ifdef SEQ_EPOCH_LOOP_EN
      r_epoch_cnt  <= w_epoch_cnt_nxt;
      r_epoch_idx  <= w_epoch_idx_nxt;
`endif
    end
  end

  // Next-state and next-datapath logic; EXEC follows HALT > illegal > code_reset > code_active.
  always_comb begin
    w_next_state     = r_state;
    w_pc_nxt         = r_pc;
    w_prog_len_nxt   = r_prog_len;
    w_instr_nxt      = r_instr;
    w_code_count_nxt = r_code_count;
    w_err_nxt        = r_err;
    w_zero_done_nxt  = 1'b0;
    w_finish         = 1'b0;
    w_loop_taken     = 1'b0;
`ifdef SEQ_EPOCH_LOOP_EN
    w_epoch_cnt_nxt  = r_epoch_cnt;
    w_epoch_idx_nxt  = r_epoch_idx;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          if (prog_len != {ADDR_W{1'b0}}) begin
            w_prog_len_nxt = prog_len;
            w_pc_nxt       = {ADDR_W{1'b0}};
            w_err_nxt      = 1'b0;
            w_next_state   = FETCH;
`ifdef SEQ_EPOCH_LOOP_EN
            w_epoch_cnt_nxt = (epoch_count == 16'd0) ? 16'd1 : epoch_count;
            w_epoch_idx_nxt = 16'd0;
`endif
          end else begin
            w_zero_done_nxt = 1'b1;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      FETCH: begin
        w_next_state = LATCH;
      end
      LATCH: begin
        w_instr_nxt      = imem_data;
        w_code_count_nxt = 32'd0;
        w_next_state     = EXEC;
      end
      EXEC: begin
        if (w_is_halt) begin
          w_finish = 1'b1;
        end else if (w_is_illegal) begin
          w_err_nxt    = 1'b1;
          w_pc_nxt     = w_pc_inc;
          w_finish     = (w_pc_inc == r_prog_len);
          w_next_state = FETCH;
        end else if (ctl_code_reset) begin
          w_pc_nxt     = {ADDR_W{1'b0}};
          w_next_state = FETCH;
        end else if (ctl_code_active) begin
          w_pc_nxt     = w_pc_inc;
          w_finish     = (w_pc_inc == r_prog_len);
          w_next_state = FETCH;
        end else begin
          w_code_count_nxt = ctl_reset ? 32'd0 : sat_inc32(r_code_count);
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase

    if (w_finish) begin
      if (w_restart) begin
        w_loop_taken = 1'b1;
        w_pc_nxt     = {ADDR_W{1'b0}};
        w_next_state = FETCH;
      end else begin
        w_loop_taken = 1'b0;
        w_next_state = DONE;
      end
    end else begin
      w_loop_taken = 1'b0;
    end

`ifdef SEQ_EPOCH_LOOP_EN
    if (w_loop_taken) begin
      w_epoch_idx_nxt = r_epoch_idx + 16'd1;
    end else begin
      w_epoch_idx_nxt = w_epoch_idx_nxt;
    end
`endif
  end

  // Output decode from the registered state.
  always_comb begin
    w_busy    = 1'b0;
    w_done    = r_zero_done;
    w_imem_rd = 1'b0;
    w_enable  = 1'b0;
    case (r_state)
      FETCH: begin
        w_busy    = 1'b1;
        w_imem_rd = 1'b1;
      end
      LATCH: begin
        w_busy = 1'b1;
      end
      EXEC: begin
        w_busy   = 1'b1;
        w_enable = 1'b1;
      end
      DONE: begin
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  assign busy       = w_busy;
  assign done       = w_done;
  assign err        = r_err;
  assign imem_rd    = w_imem_rd;
  assign imem_addr  = r_pc;
  assign enable     = w_enable;
  assign pc         = r_pc;
  assign code_count = r_code_count;
  // Controller sees the all-zero default opcode whenever it is not executing.
  assign op      = w_enable ? w_op : {OP_SIZE{1'b0}};
  assign param_a = w_enable ? r_instr[PCW-1 -: PARAM_A_SIZE] : {PARAM_A_SIZE{1'b0}};
  assign param_b = w_enable ? r_instr[PARAM_B_SIZE-1:0] : {PARAM_B_SIZE{1'b0}};
  assign param_c = w_enable ? r_instr[PCW-1:0] : {PCW{1'b0}};

endmodule

// File: tb/tb_code_sequencer.sv
// Self-checking bench for code_sequencer: directed programs plus randomized
// programs checked against a transaction-level program-walk model.
module tb_code_sequencer;

  localparam int CTL_SIZE = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  prog_len = 8'd0;
  logic        busy, done, err, imem_rd, enable;
  logic [7:0]  imem_addr, pc, param_c;
  logic [11:0] imem_data;
  logic [3:0]  op, param_a, param_b;
  logic [31:0] code_count;
  logic        ctl_reset = 1'b0, ctl_code_reset = 1'b0, ctl_code_active = 1'b0;
`ifdef SEQ_EPOCH_LOOP_EN
  logic [15:0] epoch_count = 16'd0;
  logic [15:0] epoch_idx;
`endif

  code_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_len(prog_len),
`ifdef SEQ_EPOCH_LOOP_EN
    .epoch_count(epoch_count), .epoch_idx(epoch_idx),
`endif
    .busy(busy), .done(done), .err(err), .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_data(imem_data), .op(op), .param_a(param_a), .param_b(param_b),
    .param_c(param_c), .code_count(code_count), .enable(enable), .pc(pc),
    .ctl_reset(ctl_reset), .ctl_code_reset(ctl_code_reset), .ctl_code_active(ctl_code_active)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory; garbage on the bus when not reading.
  logic [11:0] mem [0:255];
  always @(posedge clk) imem_data <= imem_rd ? mem[imem_addr] : 12'($urandom);

  int n_tests = 0;
  int n_fail  = 0;
  int cr_left, cr_pc, rs_left;
  int m_T, m_pc, m_err, m_ep;
  int exp_fetch[$], obs_fetch[$], exec_op[$], exec_cc[$], exec_pcc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counted cycles an instruction needs from the controller.
  function automatic int op_cost(input int o, input int pcv);
    if (o == 3 || o == 4 || o == 8) return CTL_SIZE;
    if (o == 7) return (pcv == 0) ? 1 : pcv;
    return 1;
  endfunction

  // Walk the program as the sequencer should, producing fetch trace and timing.
  task automatic model_run(input int len, input int ec);
    int p, ep, epochs, n, crl, rsl, o, pcv;
    bit fin, endp;
    logic [11:0] ins;
    exp_fetch.delete();
    m_T = 0;
    if (len == 0) return;
`ifdef SEQ_EPOCH_LOOP_EN
    epochs = (ec == 0) ? 1 : ec;
`else
    epochs = 1;
`endif
    m_err = 0; p = 0; ep = 0; crl = cr_left; rsl = rs_left; fin = 0;
    while (!fin && exp_fetch.size() < 4000) begin
      exp_fetch.push_back(p);
      ins = mem[p]; o = int'(ins[11:8]); pcv = int'(ins[7:0]);
      m_T += 3; endp = 0;
      if (o == 0) endp = 1;
      else if (o >= 9) begin m_err = 1; p = (p + 1) % 256; endp = (p == len); end
      else if (crl > 0 && p == cr_pc) begin crl--; p = 0; end
      else begin
        n = op_cost(o, pcv);
        if (rsl > 0 && n >= 3) begin n += 2; rsl--; end
        m_T += n - 1;
        p = (p + 1) % 256; endp = (p == len);
      end
      if (endp) begin
        if (ep + 1 < epochs) begin ep++; p = 0; end
        else fin = 1;
      end
    end
    m_pc = p; m_ep = ep;
  endtask

  // Behaviour of the op-code controller (size=3) plus scripted reset injections.
  task automatic drive_ctl();
    logic act;
    act = 1'b0; ctl_reset = 1'b0; ctl_code_reset = 1'b0;
    if (enable) begin
      case (op)
        4'd1, 4'd2, 4'd5, 4'd6: act = 1'b1;
        4'd3, 4'd4, 4'd8:       act = (code_count == 32'(CTL_SIZE - 1));
        4'd7:                   act = ((code_count + 32'd1) >= 32'(param_c));
        default:                act = 1'b0;
      endcase
      if (op >= 4'd1 && op <= 4'd8 && cr_left > 0 && pc == 8'(cr_pc)) begin
        ctl_code_reset = 1'b1; cr_left--;
      end else if (!act && rs_left > 0 && code_count == 32'd1) begin
        ctl_reset = 1'b1; rs_left--;
      end
    end
    ctl_code_active = act;
  endtask

  task automatic run_prog(input string tag, input int len, input int ec,
                          input int cr, input int crp, input int rs);
    int done_k, busy_bad, limit, nbad, nmin;
    cr_left = cr; cr_pc = crp; rs_left = rs;
    model_run(len, ec);
    obs_fetch.delete(); exec_op.delete(); exec_cc.delete(); exec_pcc.delete();
    @(negedge clk);
    prog_len = 8'(len); start = 1'b1;
`ifdef SEQ_EPOCH_LOOP_EN
    epoch_count = 16'(ec);
`endif
    @(negedge clk);
    start = 1'b0;
    done_k = -1; busy_bad = 0; limit = m_T + 40;
    for (int k = 0; k <= limit; k++) begin
      if (k == 0 && len != 0) chk({tag, "_err_clr"}, err, 1'b0);
      if (k == 1) prog_len = 8'($urandom);
      start = (k == 2 && len != 0);
      if (imem_rd) obs_fetch.push_back(int'(imem_addr));
      if (enable) begin
        exec_op.push_back(int'(op)); exec_cc.push_back(int'(code_count));
        exec_pcc.push_back(int'(param_c));
      end
      if (done) begin done_k = k; break; end
      if (busy !== 1'b1) busy_bad++;
      drive_ctl();
      @(negedge clk);
    end
    start = 1'b0;
    drive_ctl();
    chk({tag, "_done_at"}, 64'(done_k), 64'(m_T));
    chk({tag, "_busy_run"}, 64'(busy_bad), 64'd0);
    chk({tag, "_nfetch"}, 64'(obs_fetch.size()), 64'(exp_fetch.size()));
    nbad = 0;
    nmin = (obs_fetch.size() < exp_fetch.size()) ? obs_fetch.size() : exp_fetch.size();
    for (int i = 0; i < nmin; i++) if (obs_fetch[i] != exp_fetch[i]) nbad++;
    chk({tag, "_fetch_seq"}, 64'(nbad), 64'd0);
    chk({tag, "_pc"}, 64'(pc), 64'(m_pc));
    chk({tag, "_err"}, 64'(err), 64'(m_err));
`ifdef SEQ_EPOCH_LOOP_EN
    chk({tag, "_epoch_idx"}, 64'(epoch_idx), 64'(m_ep));
`endif
    @(negedge clk);
    chk({tag, "_after"}, {busy, done, enable, op, param_c}, 15'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int len, r, o, pv, nlw, nbad, n2, found, ev;
    for (int i = 0; i < 256; i++) mem[i] = 12'h100;
    m_pc = 0; m_err = 0; m_ep = 0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {busy, done, err, imem_rd, enable, pc, imem_addr, op, param_c}, 33'd0);
    chk("reset_cc", code_count, 32'd0);
    rst_n = 1'b1;

    mem[0] = 12'h100; mem[1] = 12'h305; mem[2] = 12'h7FF;
    run_prog("p1", 2, 1, 0, 0, 0);
    nlw = 0; nbad = 0;
    for (int i = 0; i < exec_op.size(); i++)
      if (exec_op[i] == 3) begin
        if (exec_cc[i] != nlw) nbad++;
        if (exec_pcc[i] != 8'h05) nbad++;
        nlw++;
      end
    chk("lw_cycles", 64'(nlw), 64'd3);
    chk("lw_cc_pc", 64'(nbad), 64'd0);

    run_prog("zlen", 0, 1, 0, 0, 0);

    mem[0] = 12'h703;
    run_prog("stall", 1, 1, 0, 0, 0);
    nlw = 0; nbad = 0;
    for (int i = 0; i < exec_op.size(); i++)
      if (exec_op[i] == 7) begin
        if (exec_cc[i] != nlw) nbad++;
        nlw++;
      end
    chk("stall_cycles", 64'(nlw), 64'd3);
    chk("stall_cc", 64'(nbad), 64'd0);

    mem[0] = 12'h100; mem[1] = 12'h000; mem[2] = 12'h200;
    run_prog("halt", 3, 1, 0, 0, 0);
    n2 = 0;
    foreach (exec_op[i]) if (exec_op[i] == 2) n2++;
    chk("halt_no_op2", 64'(n2), 64'd0);

    mem[0] = 12'hA00; mem[1] = 12'h100;
    run_prog("illegal", 2, 1, 0, 0, 0);
    mem[0] = 12'h100;
    run_prog("errclr", 1, 1, 0, 0, 0);

    mem[0] = 12'h303;
    run_prog("ctlrst", 1, 1, 0, 0, 1);

    mem[0] = 12'h100; mem[1] = 12'h100; mem[2] = 12'h100;
    run_prog("coderst", 3, 1, 1, 1, 0);

    for (int i = 0; i < 256; i++) mem[i] = 12'h100;
    run_prog("maxlen", 255, 1, 0, 0, 0);

`ifdef SEQ_EPOCH_LOOP_EN
    mem[0] = 12'h600;
    run_prog("epoch", 1, 3, 0, 0, 0);
`endif

    for (int t = 0; t < 25; t++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len + 3; i++) begin
        r = $urandom_range(0, 19);
        if (r < 14) o = $urandom_range(1, 8);
        else if (r < 16) o = 0;
        else if (r < 18) o = $urandom_range(9, 15);
        else o = 7;
        pv = $urandom_range(0, 255);
        if (o == 7) pv = $urandom_range(0, 6);
        mem[i] = {4'(o), 8'(pv)};
      end
      ev = $urandom_range(0, 3);
      run_prog($sformatf("rnd%0d", t), len, ev,
               ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, len - 1),
               ($urandom_range(0, 2) == 0) ? 1 : 0);
    end

    // Asynchronous reset in the middle of load_weight.
    mem[0] = 12'h100; mem[1] = 12'h305;
    cr_left = 0; rs_left = 0;
    @(negedge clk);
    prog_len = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; found = 0;
    for (int k = 0; k < 50; k++) begin
      if (enable && op == 4'd3 && code_count == 32'd1) begin found = 1; break; end
      drive_ctl();
      @(negedge clk);
    end
    chk("abort_reach", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {busy, done, err, imem_rd, enable, pc, imem_addr, op, param_c}, 33'd0);
    chk("abort_cc", code_count, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nbad = 0;
    for (int k = 0; k < 10; k++) begin
      drive_ctl();
      @(negedge clk);
      if (done || busy) nbad++;
    end
    chk("abort_idle", 64'(nbad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/code_sequencer.md
Name: code_sequencer

Overview:
- Sequential program sequencer that sits in front of the combinational op-code controller.
- Fetches 12-bit instructions {op, param_a, param_b} from a synchronous instruction memory and presents them to the controller.
- Maintains code_count and the program counter, reacting to the controller's reset / code_reset / code_active outputs.
- Provides a start/busy/done handshake to the host.

Parameters:
- OP_SIZE, 4, opcode width
- PARAM_A_SIZE, 4, param_a width
- PARAM_B_SIZE, 4, param_b width
- ADDR_W, 8, instruction address / program-length width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  run request, sampled only in IDLE
- prog_len  in  ADDR_W  instruction count, latched on accepted start
- busy  out  1  high in FETCH/LATCH/EXEC
- done  out  1  one-cycle pulse on program completion
- err  out  1  sticky illegal-opcode flag, cleared on accepted start
- imem_rd  out  1  instruction read strobe
- imem_addr  out  ADDR_W  instruction address (= pc)
- imem_data  in  OP_SIZE+PARAM_A_SIZE+PARAM_B_SIZE  instruction {op,param_a,param_b}, valid one cycle after imem_rd
- op  out  OP_SIZE  to controller
- param_a  out  PARAM_A_SIZE  to controller
- param_b  out  PARAM_B_SIZE  to controller
- param_c  out  PARAM_A_SIZE+PARAM_B_SIZE  {param_a,param_b}
- code_count  out  32  cycles spent in current instruction
- enable  out  1  high only in EXEC
- pc  out  ADDR_W  current program counter
- ctl_reset  in  1  controller "reset" (clear code_count)
- ctl_code_reset  in  1  controller code_reset (pc to 0)
- ctl_code_active  in  1  controller code_active (advance pc)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; pc=0; code_count=0; instruction register=0; busy=0; done=0; err=0; imem_rd=0; enable=0.
- Outside EXEC, op/param_a/param_b/param_c are driven 0; 4'b0000 is the controller's all-zero default.
- IDLE:
  - start=1 and prog_len!=0: latch prog_len, pc<=0, err<=0, go to FETCH.
  - start=1 and prog_len==0: done pulses the next cycle; stay IDLE.
  - start while busy is ignored.
- FETCH (1 cycle): imem_rd=1, imem_addr=pc; go to LATCH.
- LATCH (1 cycle): capture imem_data into instruction register; code_count<=0; go to EXEC.
- EXEC: enable=1; op/params come from the instruction register; controller outputs are sampled each cycle. Priority, highest first:
  1. op==4'b0000 (HALT): go to DONE; controller inputs ignored.
  2. op in 4'b1001..4'b1111 (illegal): err<=1, pc<=pc+1, then the end-check below; one EXEC cycle only.
  3. ctl_code_reset: pc<=0, go to FETCH.
  4. ctl_code_active: pc<=pc+1; if pc+1==prog_len go to DONE, else go to FETCH.
  5. Otherwise stay in EXEC. code_count<=0 if ctl_reset, else code_count+1, saturating at 32'hFFFF_FFFF.
- ctl_reset together with ctl_code_active: pc advances; code_count is reloaded 0 in LATCH anyway.
- pc wrap: pc+1 is computed in ADDR_W bits. prog_len=2^ADDR_W is not representable; the maximum program is 2^ADDR_W-1 instructions.
- DONE (1 cycle): done=1, busy=0; go to IDLE. pc holds its final value until the next start.
- Latency: a single-cycle instruction takes 3 clocks (FETCH, LATCH, EXEC). An instruction needing N counted cycles takes N+2 clocks.
- Asynchronous reset mid-program aborts immediately with no done pulse.

Optional Feature:
- Macro: SEQ_EPOCH_LOOP_EN.
- Defined:
  - Adds input epoch_count[15:0], latched on start; 0 is treated as 1.
  - Adds output epoch_idx[15:0], reset 0, cleared on start.
  - At program end (HALT or pc+1==prog_len): if epoch_idx+1 < epoch_count, then epoch_idx++, pc<=0, go to FETCH with no done pulse; otherwise go to DONE.
- Undefined: single pass; these ports are absent.

Decomposition:
- Package nn_ctrl_pkg holds:
  - opcode localparams (set_act_dense=1, set_cost=2, load_weight=3, load_input_label=4, set_learning_rate=5, update_weight=6, stall=7, load_z=8, HALT=0);
  - instruction width;
  - seq_state_t enum {IDLE, FETCH, LATCH, EXEC, DONE}.
- No sub-module: the block stays flat.

Test Plan:
- Test setup: controller instantiated with size=3.
- Program [0x100, 0x305], prog_len=2, start pulse:
  - done asserts 3+5 clocks after start;
  - during load_weight, code_count goes 0,1,2 and param_c=8'h05;
  - final pc=2, err=0.
- Stall 0x703 alone, prog_len=1: EXEC lasts 3 cycles (code_count 0,1,2), then done.
- Program [0x100, 0x000, 0x200], prog_len=3: HALT at pc=1 gives done; op 2 is never fetched; final pc=1.
- Illegal 0xA00 then 0x100, prog_len=2: err=1 after the first EXEC, program completes, done pulses; the next start clears err.
- rst_n low mid load_weight (code_count=1): all outputs are 0 immediately, no done, then IDLE.
- With SEQ_EPOCH_LOOP_EN, epoch_count=3, program [0x600], prog_len=1:
  - update_weight is executed 3 times;
  - epoch_idx steps 0→1→2;
  - a single done pulse is issued.
